// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller bundle: register addresses and control bits in,
// stall/flush/forward controls and performance counters out.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rs1E;
    logic [4:0]       rs2E;
    logic [4:0]       rdE;
    logic [4:0]       rdM;
    logic [4:0]       rdW;
    logic             memReadE;
    logic             regWriteM;
    logic             regWriteW;
    logic             pcSrcE;
    logic             dmemReq;
    logic             dmemReady;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             halted;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    // datapath side
    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output memReadE, regWriteM, regWriteW, pcSrcE, dmemReq, dmemReady,
        input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushW, halted, stallCnt, flushCnt
    );

    // controller side
    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  memReadE, regWriteM, regWriteW, pcSrcE, dmemReq, dmemReady,
        output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
        output flushD, flushE, flushW, halted, stallCnt, flushCnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use stalls,
// EX redirects, data-memory wait states with a timeout watchdog, perf counters.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_controller_if.slave hz
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

    logic mem_stall;
    logic load_use;
    logic redirect;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    // Operand forwarding: MEM result wins over WB, x0 is never forwarded.
    logic [4:0] rs_e   [2];
    logic [1:0] fwd_sel[2];

    assign rs_e[0] = hz.rs1E;
    assign rs_e[1] = hz.rs2E;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                !rst                                                        ? 2'b00 :
                (hz.regWriteM && (hz.rdM != 5'd0) && (hz.rdM == rs_e[gi])) ? 2'b10 :
                (hz.regWriteW && (hz.rdW != 5'd0) && (hz.rdW == rs_e[gi])) ? 2'b01 :
                                                                              2'b00;
        end
    endgenerate

    assign hz.forwardAE = fwd_sel[0];
    assign hz.forwardBE = fwd_sel[1];

    assign mem_stall = hz.dmemReq && !hz.dmemReady;
    assign load_use  = hz.memReadE && (hz.rdE != 5'd0) &&
                       ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        redirect      = 1'b0;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_w       = 1'b0;

        unique case (state_reg)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                    // The entry cycle in RUN is not counted; MEM_WAIT cycles are.
                    if (state_reg == RUN) begin
                        state_next    = MEM_WAIT;
                        wait_cnt_next = '0;
                    end else if (wait_cnt_reg >= WAIT_LAST) begin
                        state_next = HALT;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    if (hz.pcSrcE) begin
                        // Wrong-path ID instruction makes any load-use moot.
                        redirect = 1'b1;
                        flush_d  = 1'b1;
                        flush_e  = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            end
            HALT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end
            default: begin
                state_next = HALT;
            end
        endcase

        if (!rst) begin
            redirect = 1'b0;
            stall_f  = 1'b0;
            stall_d  = 1'b0;
            stall_e  = 1'b0;
            stall_m  = 1'b0;
            flush_d  = 1'b0;
            flush_e  = 1'b0;
            flush_w  = 1'b0;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (stall_f && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_next = stall_cnt_reg + 1'b1;
        if (redirect && (flush_cnt_reg != {CNT_W{1'b1}}))
            flush_cnt_next = flush_cnt_reg + 1'b1;
    end

    assign hz.stallF   = stall_f;
    assign hz.stallD   = stall_d;
    assign hz.stallE   = stall_e;
    assign hz.stallM   = stall_m;
    assign hz.flushD   = flush_d;
    assign hz.flushE   = flush_e;
    assign hz.flushW   = flush_w;
    assign hz.halted   = (state_reg == HALT);
    assign hz.stallCnt = stall_cnt_reg;
    assign hz.flushCnt = flush_cnt_reg;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a MEM_TIMEOUT=4 instance for the hazard
// scenarios and a CNT_W=4 instance for counter saturation.
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(32)) hz ();
    hazard_controller_if #(.CNT_W(4))  hs ();

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    hazard_controller #(.MEM_TIMEOUT(255), .CNT_W(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .hz  (hs)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_main();
        hz.rs1D = 5'd0; hz.rs2D = 5'd0; hz.rs1E = 5'd0; hz.rs2E = 5'd0;
        hz.rdE = 5'd0;  hz.rdM = 5'd0;  hz.rdW = 5'd0;
        hz.memReadE = 1'b0; hz.regWriteM = 1'b0; hz.regWriteW = 1'b0;
        hz.pcSrcE = 1'b0; hz.dmemReq = 1'b0; hz.dmemReady = 1'b0;
    endtask

    task automatic clear_small();
        hs.rs1D = 5'd0; hs.rs2D = 5'd0; hs.rs1E = 5'd0; hs.rs2E = 5'd0;
        hs.rdE = 5'd0;  hs.rdM = 5'd0;  hs.rdW = 5'd0;
        hs.memReadE = 1'b0; hs.regWriteM = 1'b0; hs.regWriteW = 1'b0;
        hs.pcSrcE = 1'b0; hs.dmemReq = 1'b0; hs.dmemReady = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        clear_main();
        clear_small();

        // Reset: counters clear, outputs forced low even with hazards present
        hz.regWriteM = 1'b1; hz.rdM = 5'd3; hz.rs1E = 5'd3; hz.dmemReq = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rst_fwdA", 32'(hz.forwardAE), 32'h0);
        check_eq("rst_stallF", 32'(hz.stallF), 32'h0);
        check_eq("rst_flushW", 32'(hz.flushW), 32'h0);
        check_eq("rst_halted", 32'(hz.halted), 32'h0);
        check_eq("rst_stallCnt", hz.stallCnt, 32'd0);
        check_eq("rst_flushCnt", hz.flushCnt, 32'd0);
        clear_main();
        rst = 1'b1;

        // Load-use: lw x5 in EX, add x6,x5,x2 in ID
        hz.memReadE = 1'b1; hz.rdE = 5'd5; hz.rs1D = 5'd5; hz.rs2D = 5'd2;
        #1;
        check_eq("lu_stallF", 32'(hz.stallF), 32'h1);
        check_eq("lu_stallD", 32'(hz.stallD), 32'h1);
        check_eq("lu_flushE", 32'(hz.flushE), 32'h1);
        check_eq("lu_stallE", 32'(hz.stallE), 32'h0);
        check_eq("lu_flushD", 32'(hz.flushD), 32'h0);
        tick();
        clear_main();
        hz.rs1E = 5'd5; hz.rs2E = 5'd2; hz.rdE = 5'd6;
        hz.regWriteW = 1'b1; hz.rdW = 5'd5;
        #1;
        check_eq("lu_next_stallF", 32'(hz.stallF), 32'h0);
        check_eq("lu_next_fwdA", 32'(hz.forwardAE), 32'h1);
        check_eq("lu_next_fwdB", 32'(hz.forwardBE), 32'h0);
        check_eq("lu_stallCnt", hz.stallCnt, 32'd1);

        // Forwarding priority
        clear_main();
        hz.regWriteM = 1'b1; hz.rdM = 5'd3; hz.regWriteW = 1'b1; hz.rdW = 5'd3;
        hz.rs1E = 5'd3; hz.rs2E = 5'd3;
        #1;
        check_eq("fwd_mem_A", 32'(hz.forwardAE), 32'h2);
        check_eq("fwd_mem_B", 32'(hz.forwardBE), 32'h2);
        hz.regWriteM = 1'b0;
        #1;
        check_eq("fwd_nowrM_A", 32'(hz.forwardAE), 32'h1);
        hz.regWriteM = 1'b1; hz.rdM = 5'd0;
        #1;
        check_eq("fwd_rdM0_A", 32'(hz.forwardAE), 32'h1);
        hz.rdW = 5'd0;
        #1;
        check_eq("fwd_none_A", 32'(hz.forwardAE), 32'h0);
        check_eq("fwd_none_B", 32'(hz.forwardBE), 32'h0);

        // Redirect overrides simultaneous load-use
        clear_main();
        hz.pcSrcE = 1'b1; hz.memReadE = 1'b1; hz.rdE = 5'd5; hz.rs1D = 5'd5;
        #1;
        check_eq("br_flushD", 32'(hz.flushD), 32'h1);
        check_eq("br_flushE", 32'(hz.flushE), 32'h1);
        check_eq("br_stallF", 32'(hz.stallF), 32'h0);
        check_eq("br_stallD", 32'(hz.stallD), 32'h0);
        tick();
        clear_main();
        #1;
        check_eq("br_flushCnt", hz.flushCnt, 32'd1);
        check_eq("br_stallCnt", hz.stallCnt, 32'd1);

        // Three-cycle memory wait with a redirect request ignored
        do_reset();
        hz.dmemReq = 1'b1; hz.dmemReady = 1'b0; hz.pcSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("mw%0d_stallF", i), 32'(hz.stallF), 32'h1);
            check_eq($sformatf("mw%0d_stallM", i), 32'(hz.stallM), 32'h1);
            check_eq($sformatf("mw%0d_flushW", i), 32'(hz.flushW), 32'h1);
            check_eq($sformatf("mw%0d_flushD", i), 32'(hz.flushD), 32'h0);
            tick();
        end
        hz.dmemReady = 1'b1; hz.pcSrcE = 1'b0;
        #1;
        check_eq("mw_rel_stallF", 32'(hz.stallF), 32'h0);
        check_eq("mw_rel_stallE", 32'(hz.stallE), 32'h0);
        check_eq("mw_rel_flushW", 32'(hz.flushW), 32'h0);
        tick();
        clear_main();
        #1;
        check_eq("mw_stallCnt", hz.stallCnt, 32'd3);
        check_eq("mw_flushCnt", hz.flushCnt, 32'd0);
        hz.pcSrcE = 1'b1;
        #1;
        check_eq("mw_run_flushD", 32'(hz.flushD), 32'h1);
        clear_main();

        // Watchdog: RUN entry cycle plus 4 counted MEM_WAIT cycles -> HALT
        do_reset();
        hz.dmemReq = 1'b1; hz.dmemReady = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("to_not_yet", 32'(hz.halted), 32'h0);
        tick();
        check_eq("to_halted", 32'(hz.halted), 32'h1);
        hz.dmemReady = 1'b1; hz.pcSrcE = 1'b1;
        #1;
        check_eq("halt_stallF", 32'(hz.stallF), 32'h1);
        check_eq("halt_stallM", 32'(hz.stallM), 32'h1);
        check_eq("halt_flushW", 32'(hz.flushW), 32'h1);
        check_eq("halt_flushD", 32'(hz.flushD), 32'h0);
        tick();
        check_eq("halt_sticky", 32'(hz.halted), 32'h1);
        check_eq("halt_stallCnt", hz.stallCnt, 32'd6);
        check_eq("halt_flushCnt", hz.flushCnt, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("halt_rstlow_stallF", 32'(hz.stallF), 32'h0);
        tick();
        rst = 1'b1;
        clear_main();
        #1;
        check_eq("halt_rst_halted", 32'(hz.halted), 32'h0);
        check_eq("halt_rst_stallCnt", hz.stallCnt, 32'd0);
        check_eq("halt_rst_stallF", 32'(hz.stallF), 32'h0);

        // Saturation on the 4-bit counter instance
        hs.dmemReq = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_stallCnt", 32'(hs.stallCnt), 32'd15);
        check_eq("sat_no_halt", 32'(hs.halted), 32'h0);
        clear_small();
        hs.pcSrcE = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_flushCnt", 32'(hs.flushCnt), 32'd15);
        check_eq("sat_stallCnt_hold", 32'(hs.stallCnt), 32'd15);
        clear_small();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central sequencing controller for the 5-stage RV32I pipeline. Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding mux selects.
- Resolves three hazard classes:
  - load-use data hazards
  - control-flow redirects resolved in EX
  - multi-cycle data-memory wait states, with a timeout watchdog
- Exposes saturating performance counters.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive wait cycles on a data-memory access before the controller halts the pipeline.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rs1D  in  5  source register 1 of the instruction in ID
- rs2D  in  5  source register 2 of the instruction in ID
- rs1E  in  5  source register 1 of the instruction in EX
- rs2E  in  5  source register 2 of the instruction in EX
- rdE  in  5  destination register in EX
- rdM  in  5  destination register in MEM
- rdW  in  5  destination register in WB
- memReadE  in  1  EX instruction is a load
- regWriteM  in  1  MEM instruction writes the register file
- regWriteW  in  1  WB instruction writes the register file
- pcSrcE  in  1  taken branch / jal / jalr resolved in EX this cycle
- dmemReq  in  1  MEM stage is issuing a load or store
- dmemReady  in  1  data memory completes the access this cycle
- forwardAE  out  2  00 register file, 10 ALU result from MEM, 01 result from WB
- forwardBE  out  2  same encoding as forwardAE, for operand B
- stallF  out  1  hold the PC
- stallD  out  1  hold IF/ID
- stallE  out  1  hold ID/EX
- stallM  out  1  hold EX/MEM
- flushD  out  1  clear IF/ID
- flushE  out  1  clear ID/EX
- flushW  out  1  clear MEM/WB (insert bubble)
- halted  out  1  sticky memory-timeout error; pipeline frozen
- stallCnt  out  CNT_W  cycles in which stallF was asserted
- flushCnt  out  CNT_W  control-flow redirects taken

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. All state changes occur on posedge clk.
- Reset (rst=0 at a clock edge):
  - state goes to RUN; wait counter goes to 0; halted=0; stallCnt=0; flushCnt=0.
  - This applies from any state, including mid-wait or HALT.
  - While rst=0, all combinational stall and flush outputs are forced to 0 and forwarding selects to 00.
- Forwarding (combinational, every state):
  - forwardAE=10 if regWriteM && rdM!=0 && rdM==rs1E.
  - Else forwardAE=01 if regWriteW && rdW!=0 && rdW==rs1E.
  - Else forwardAE=00.
  - MEM has priority over WB. forwardBE is identical, using rs2E.
- memStall = dmemReq && !dmemReady, evaluated in RUN and MEM_WAIT.
- Priority, highest first: HALT > memStall > pcSrcE > load-use.
- Memory stall (RUN or MEM_WAIT):
  - stallF=stallD=stallE=stallM=1 and flushW=1.
  - pcSrcE and load-use are ignored; they re-evaluate once the stall releases.
  - The transition RUN→MEM_WAIT happens on the first memStall cycle.
  - In MEM_WAIT the wait counter increments each memStall cycle.
  - When dmemReady=1, return to RUN and clear the wait counter. There are no stalls in that cycle (zero-latency release).
  - If the wait counter reaches MEM_TIMEOUT while still stalled, go to HALT.
  - A single-cycle access (dmemReady=1 on the first cycle) never leaves RUN.
- Redirect (pcSrcE=1, no memStall): flushD=1 and flushE=1, no stalls, flushCnt increments. This overrides a simultaneous load-use: the ID instruction is wrong-path.
- Load-use: condition is memReadE && rdE!=0 && (rdE==rs1D || rdE==rs2D), with no memStall and no pcSrcE. Response: stallF=stallD=1, flushE=1, for exactly one cycle per occurrence.
- HALT:
  - stallF, stallD, stallE and stallM held at 1; flushW=1; halted=1.
  - Flushes from pcSrcE are suppressed.
  - HALT is exited only by reset.
- stallCnt increments each cycle stallF=1, including HALT cycles. Both counters saturate at all-ones and never wrap.
- No registered output has added latency: all stall, flush and forward outputs are combinational from the inputs and the current state.

Test Plan:
- lw x5,0(x1) in EX; add x6,x5,x2 in ID; dmemReq=0 → exactly one cycle of stallF=stallD=flushE=1. Next cycle forwardAE=01 (x5 from WB). stallCnt=1.
- add x3 in MEM and add x3 in WB, both regWrite; rs1E=3 → forwardAE=10. Repeat with rdM=0 → forwardAE=01. Repeat with rdW=0 as well → forwardAE=00.
- pcSrcE=1 while load-use is also present → flushD=flushE=1, stallF=0, flushCnt=1.
- dmemReq=1, dmemReady=0 for 3 cycles, then 1 → stallF..stallM=1 and flushW=1 for 3 cycles. On the 4th cycle all stalls are 0, state is RUN, stallCnt=3. pcSrcE=1 during the wait → flushCnt stays 0.
- MEM_TIMEOUT=4; dmemReq=1, dmemReady held 0 → halted=1 after the wait counter reaches 4. Stalls persist through later dmemReady=1. Drive rst=0 for one edge → halted=0, both counters=0, state RUN.
- Preload stallCnt near saturation (CNT_W=4 build) and hold a memory stall for 20 cycles → stallCnt sticks at 15.
